stereo_pack_fifo: RTL
=====================

// Module: stereo_pack_fifo
// PURPOSE
//  Consumes the two 12-bit MCP3201 sample streams (ldata/lstrb, rdata/rstrb) from dual_mcp3201_pmod.
//  Pairs L and R into one stereo frame and converts offset-binary to signed 16-bit.
//  Buffers frames in a small FIFO, presented as a valid/ready stream for the next sink (UART/I2S/DMA).
// PARAMETERS
//  DEPTH         16    FIFO depth in 32-bit frames; power of 2, >=4
//  PAIR_TIMEOUT  1024  max clocks a lone half-frame is held before discard; >=2
// PORTS
//  clock     in   1             system clock (50 MHz in current build)
//  reset     in   1             synchronous, active-high
//  ldata     in   12            left sample, valid when lstrb=1
//  lstrb     in   1             single-cycle left-sample strobe
//  rdata     in   12            right sample, valid when rstrb=1
//  rstrb     in   1             single-cycle right-sample strobe
//  m_data    out  32            frame {L16, R16}, stable while m_valid & ~m_ready
//  m_valid   out  1             FIFO not empty
//  m_ready   in   1             consumer accepts when m_valid & m_ready
//  level     out  $clog2(DEPTH)+1  frames currently stored
//  dropped   out  1             1-cycle pulse: held half-frame discarded (timeout/duplicate)
//  overflow  out  1             sticky: complete frame lost because FIFO full; cleared by reset only
// BEHAVIOUR
//  Reset: pairing FSM IDLE, timeout counter 0, FIFO empty; m_valid=0, level=0, dropped=0, overflow=0, m_data=don't-care.
//  Conversion: s16 = {~x[11], x[10:0], 4'b0000} (0x000->0x8000, 0x800->0x0000, 0xFFF->0x7FF0).
//  Pairing FSM (states IDLE, HAVE_L, HAVE_R):
//   IDLE:   lstrb&rstrb -> push frame, stay IDLE; lstrb only -> latch L, HAVE_L; rstrb only -> latch R, HAVE_R.
//   HAVE_L: rstrb -> push {Lheld,R}; if lstrb same cycle, latch new L, stay HAVE_L, else IDLE.
//           lstrb only -> replace held L, dropped=1, stay, timer cleared.
//   HAVE_R: mirror of HAVE_L.
//   Timer counts cycles in HAVE_*; reaching PAIR_TIMEOUT-1 with no completing strobe -> dropped=1, IDLE.
//  Latency: frame completed on strobe cycle N is written at edge ending N; m_valid=1 in N+1 if FIFO was empty.
//  FIFO: m_data combinationally read from head (distributed RAM); pop on m_valid&m_ready.
//   Push when full and no pop: frame discarded, overflow<=1, level unchanged.
//   Push when full with pop same cycle: both occur, level stays DEPTH, no overflow.
//   Push+pop when empty: push only (no pass-through); m_valid next cycle.
//   Pointers wrap modulo DEPTH; level = wr_cnt - rd_cnt using one extra bit.
//  Reset mid-operation: held half-frame and all FIFO contents discarded; next frame starts clean.
// CONFIGURATION
//  STEREO_PACK_SEQ_EN defined: 4-bit frame sequence counter (reset 0, +1 per accepted push, wraps 15->0)
//   replaces m_data[3:0]; frames discarded on overflow do not advance it.
//  Not defined: m_data[3:0] = 4'b0000 (pure conversion); no counter logic.
// STRUCTURE
//  Package stereo_pkg: SAMPLE_W=12, PCM_W=16, frame_t (packed struct l,r), pair_state_t enum,
//   function to_pcm16(logic [11:0]) implementing the conversion above.
//  Sub-module sync_fifo #(WIDTH,DEPTH): single-clock FIFO with full/empty/level; pairing FSM in top.
// TESTING
//  1. lstrb,ldata=0x800 then 10 cycles later rstrb,rdata=0xFFF -> one frame 0x00007FF0, m_valid 1 cycle after rstrb.
//  2. lstrb&rstrb same cycle, L=0x000, R=0x800 -> frame 0x80000000, no dropped pulse.
//  3. lstrb twice (0x111, 0x222) then rstrb 0x333 -> dropped pulse on 2nd L; frame {to_pcm16(0x222),to_pcm16(0x333)}.
//  4. lone lstrb, no rstrb for PAIR_TIMEOUT cycles -> dropped pulse, FSM IDLE, later rstrb starts HAVE_R, no frame.
//  5. m_ready=0, push DEPTH+1 frames -> level=DEPTH, overflow=1 sticky; drain yields first DEPTH frames in order.
//  6. full FIFO, push and pop same cycle -> level stays DEPTH, overflow stays 0; with STEREO_PACK_SEQ_EN, seq fields 0..15,0 contiguous.

Source files
------------

// File: rtl/stereo_pkg.sv
// ----------------------------------------------------------------------------
// stereo_pkg
// Shared types and helpers for the stereo sample packer.
//   SAMPLE_W     : width of one raw MCP3201 sample (offset binary)
//   PCM_W        : width of one converted signed PCM sample
//   frame_t      : one stereo frame, left sample in the upper half
//   pair_state_t : states of the L/R pairing machine
//   to_pcm16()   : offset-binary 12-bit -> signed 16-bit, left justified
// ----------------------------------------------------------------------------
package stereo_pkg;

  localparam int SAMPLE_W = 12;
  localparam int PCM_W    = 16;

  typedef struct packed {
    logic [PCM_W-1:0] l;
    logic [PCM_W-1:0] r;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_L = 2'd1,
    ST_HAVE_R = 2'd2
  } pair_state_t;

  // Flipping the MSB turns offset binary into two's complement; the four
  // zero LSBs scale the 12-bit code to full 16-bit range.
  function automatic logic [PCM_W-1:0] to_pcm16(input logic [SAMPLE_W-1:0] x);
    return {~x[11], x[10:0], 4'b0000};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read (distributed RAM style).
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, empties the FIFO
//   push_i     : write request, data_i is the word to store
//   pop_i      : read request, honoured only while not empty
//   data_o     : head word, valid while empty_o = 0
//   empty_o    : no words stored
//   level_o    : number of words stored (0..DEPTH)
//   overflow_o : push refused this cycle because full and no pop
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// A push into an empty FIFO is never passed straight to data_o.
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [LVL_W-1:0] wr_q, wr_d;
  logic [LVL_W-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign level_o    = wr_q - rd_q;
  assign empty_o    = (wr_q == rd_q);
  assign full_s     = (level_o == LVL_W'(DEPTH));
  assign do_pop_s   = pop_i & ~empty_o;
  assign do_push_s  = push_i & (~full_s | do_pop_s);
  assign overflow_o = push_i & full_s & ~do_pop_s;
  assign data_o     = mem_q[rd_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + LVL_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + LVL_W'(1);
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/stereo_pack_fifo.sv
// ----------------------------------------------------------------------------
// stereo_pack_fifo
// Pairs the left and right MCP3201 sample strobes into stereo frames,
// converts each sample to signed 16-bit PCM and buffers the frames in a
// FIFO presented as a valid/ready stream.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   ldata/lstrb       : left sample and its single-cycle strobe
//   rdata/rstrb       : right sample and its single-cycle strobe
//   m_data            : frame {L16, R16} at the FIFO head
//   m_valid/m_ready   : stream handshake, pop on m_valid & m_ready
//   level             : frames stored
//   dropped           : one-cycle pulse, a held half-frame was discarded
//                       (timeout or repeated same-side strobe); appears the
//                       cycle after the event
//   overflow          : sticky, a complete frame was lost to a full FIFO
// Build option STEREO_PACK_SEQ_EN: m_data[3:0] carries a 4-bit sequence
// number of accepted frames instead of the (always zero) PCM LSBs.
// ----------------------------------------------------------------------------
module stereo_pack_fifo
  import stereo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PAIR_TIMEOUT = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_W-1:0]     ldata,
  input  logic                    lstrb,
  input  logic [SAMPLE_W-1:0]     rdata,
  input  logic                    rstrb,
  output logic [2*PCM_W-1:0]      m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    dropped,
  output logic                    overflow
);

  localparam int                TW         = $clog2(PAIR_TIMEOUT);
  localparam logic [TW-1:0]     TIMER_LAST = TW'(PAIR_TIMEOUT - 1);

  pair_state_t         state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic                dropped_q, dropped_d;
  logic                overflow_q;

  logic                push_s;
  logic [SAMPLE_W-1:0] push_l_s;
  logic [SAMPLE_W-1:0] push_r_s;
  frame_t              frame_s;
  logic [2*PCM_W-1:0]  fifo_din_s;
  logic                fifo_empty_s;
  logic                fifo_ovf_s;

  // Pairing decisions: which frame completes this cycle and what is held next.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    held_d    = held_q;
    dropped_d = 1'b0;
    push_s    = 1'b0;
    push_l_s  = ldata;
    push_r_s  = rdata;
    case (state_q)
      ST_IDLE: begin
        if (lstrb && rstrb) begin
          push_s = 1'b1;
        end else if (lstrb) begin
          held_d  = ldata;
          timer_d = '0;
          state_d = ST_HAVE_L;
        end else if (rstrb) begin
          held_d  = rdata;
          timer_d = '0;
          state_d = ST_HAVE_R;
        end else begin
          timer_d = '0;
        end
      end
      ST_HAVE_L: begin
        if (rstrb) begin
          // Completing strobe wins over a timeout in the same cycle.
          push_s   = 1'b1;
          push_l_s = held_q;
          timer_d  = '0;
          if (lstrb) begin
            held_d = ldata;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (lstrb) begin
          held_d    = ldata;
          timer_d   = '0;
          dropped_d = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          timer_d   = '0;
          dropped_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_HAVE_R: begin
        if (lstrb) begin
          push_s   = 1'b1;
          push_r_s = held_q;
          timer_d  = '0;
          if (rstrb) begin
            held_d = rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rstrb) begin
          held_d    = rdata;
          timer_d   = '0;
          dropped_d = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          timer_d   = '0;
          dropped_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Pairing state, hold register and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      held_q     <= '0;
      dropped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      held_q     <= held_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_q | fifo_ovf_s;
    end
  end

  // Frame assembly.
  always_comb begin
    frame_s.l = to_pcm16(push_l_s);
    frame_s.r = to_pcm16(push_r_s);
  end

`ifdef STEREO_PACK_SEQ_EN
  logic [3:0] seq_q;

  // Sequence number advances only on frames the FIFO actually stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q <= 4'd0;
    end else if (push_s && !fifo_ovf_s) begin
      seq_q <= seq_q + 4'd1;
    end else begin
      seq_q <= seq_q;
    end
  end

  assign fifo_din_s = {frame_s[2*PCM_W-1:4], seq_q};
`else
  assign fifo_din_s = frame_s;
`endif

  sync_fifo #(
    .WIDTH (2*PCM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push_s),
    .data_i     (fifo_din_s),
    .pop_i      (m_ready),
    .data_o     (m_data),
    .empty_o    (fifo_empty_s),
    .level_o    (level),
    .overflow_o (fifo_ovf_s)
  );

  assign m_valid  = ~fifo_empty_s;
  assign dropped  = dropped_q;
  assign overflow = overflow_q;

endmodule
